// File: rtl/scm_arb_pkg.sv
// Shared helpers for the SCM port arbiter: round-robin pointer advance.
// Pure combinational functions, no state.
package scm_arb_pkg;

  function automatic int unsigned rr_next(input int unsigned k, input int unsigned n);
    return (k + 1 >= n) ? 0 : k + 1;
  endfunction

endpackage

// File: rtl/scm_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past the winner.
// Zero-latency grant; a requester not granted simply keeps requesting.
module scm_rr_arbiter
  import scm_arb_pkg::*;
#(
  parameter int unsigned N_CLIENTS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CLIENTS-1:0] req_i,
  output logic [N_CLIENTS-1:0] gnt_o
);

  localparam int unsigned IDX_W = $clog2(N_CLIENTS);
  typedef logic [IDX_W-1:0] client_idx_t;

  client_idx_t ptr_q, ptr_d;
  logic        found;

  // Scan offsets from the pointer; the inner loop keeps every bit select constant.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    for (int unsigned o = 0; o < N_CLIENTS; o++) begin
      for (int unsigned i = 0; i < N_CLIENTS; i++) begin
        if (!found && req_i[i] && (((32'(ptr_q) + o) % N_CLIENTS) == i)) begin
          found    = 1'b1;
          gnt_o[i] = 1'b1;
          ptr_d    = client_idx_t'(rr_next(i, N_CLIENTS));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/scm_1r1w_port_arbiter.sv
// Shares a 1R1W SCM regfile among N_CLIENTS with independent RR read/write arbiters.
// Grants are combinational; read data returns registered one cycle after grant, no backpressure on responses.
module scm_1r1w_port_arbiter
  import scm_arb_pkg::*;
#(
  parameter int unsigned N_CLIENTS  = 4,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_CLIENTS-1:0]            rd_req_i,
  input  logic [N_CLIENTS*ADDR_WIDTH-1:0] rd_addr_i,
  output logic [N_CLIENTS-1:0]            rd_gnt_o,
  output logic [N_CLIENTS-1:0]            rd_valid_o,
  output logic [DATA_WIDTH-1:0]           rd_data_o,
  input  logic [N_CLIENTS-1:0]            wr_req_i,
  input  logic [N_CLIENTS*ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [N_CLIENTS*DATA_WIDTH-1:0] wr_data_i,
  output logic [N_CLIENTS-1:0]            wr_gnt_o,
  output logic                            ReadEnable,
  output logic [ADDR_WIDTH-1:0]           ReadAddr,
  input  logic [DATA_WIDTH-1:0]           ReadData,
  output logic                            WriteEnable,
  output logic [ADDR_WIDTH-1:0]           WriteAddr,
  output logic [DATA_WIDTH-1:0]           WriteData
);

  logic [N_CLIENTS-1:0]  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  scm_rr_arbiter #(.N_CLIENTS(N_CLIENTS)) u_rd_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (rd_req_i),
    .gnt_o (rd_gnt_o)
  );

  scm_rr_arbiter #(.N_CLIENTS(N_CLIENTS)) u_wr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (wr_req_i),
    .gnt_o (wr_gnt_o)
  );

  // Grants are one-hot, so OR-muxing yields the winner's fields and zero when idle.
  always_comb begin
    ReadAddr  = '0;
    WriteAddr = '0;
    WriteData = '0;
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      if (rd_gnt_o[i]) ReadAddr = ReadAddr | rd_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
      if (wr_gnt_o[i]) begin
        WriteAddr = WriteAddr | wr_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        WriteData = WriteData | wr_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    ReadEnable  = |rd_gnt_o;
    WriteEnable = |wr_gnt_o;
  end

  always_comb begin
    rd_valid_d = rd_gnt_o;
    rd_data_d  = ReadEnable ? ReadData : rd_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;

endmodule

// File: tb/tb_scm_1r1w_port_arbiter.sv
// Directed bench: grant checks inline, read responses checked by a scoreboard monitor.
module tb_scm_1r1w_port_arbiter;

  localparam int NC = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NC-1:0]   rd_req_i = '0;
  logic [NC*AW-1:0] rd_addr_i = '0;
  logic [NC-1:0]   rd_gnt_o, rd_valid_o;
  logic [DW-1:0]   rd_data_o;
  logic [NC-1:0]   wr_req_i = '0;
  logic [NC*AW-1:0] wr_addr_i = '0;
  logic [NC*DW-1:0] wr_data_i = '0;
  logic [NC-1:0]   wr_gnt_o;
  logic            ReadEnable, WriteEnable;
  logic [AW-1:0]   ReadAddr, WriteAddr;
  logic [DW-1:0]   ReadData, WriteData;

  int checks = 0;
  int failures = 0;
  logic [NC+DW-1:0] exp_q[$];

  scm_1r1w_port_arbiter #(.N_CLIENTS(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_gnt_o(rd_gnt_o),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
    .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_gnt_o(wr_gnt_o),
    .ReadEnable(ReadEnable), .ReadAddr(ReadAddr), .ReadData(ReadData),
    .WriteEnable(WriteEnable), .WriteAddr(WriteAddr), .WriteData(WriteData)
  );

  always #5 clk = ~clk;

  // Regfile model: unwritten words read as 0xA0000000 + address.
  logic [DW-1:0] mem [32];
  logic [31:0]   wr_seen;
  always @(posedge clk) begin
    if (!rst_n) wr_seen <= '0;
    else if (WriteEnable) begin
      mem[WriteAddr]     <= WriteData;
      wr_seen[WriteAddr] <= 1'b1;
    end
  end
  assign ReadData = wr_seen[ReadAddr] ? mem[ReadAddr] : 32'hA000_0000 + 32'(ReadAddr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [NC-1:0] v, input logic [DW-1:0] d);
    exp_q.push_back({v, d});
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_raddr(input int c, input logic [AW-1:0] a);
    rd_addr_i[c*AW +: AW] = a;
  endtask

  task automatic set_w(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_addr_i[c*AW +: AW] = a;
    wr_data_i[c*DW +: DW] = d;
  endtask

  // Response monitor
  initial begin
    logic [NC+DW-1:0] e;
    forever begin
      @(negedge clk);
      if (rd_valid_o != '0) begin
        if (exp_q.size() == 0) begin
          chk("rd_resp_unexpected", {28'h0, rd_valid_o, rd_data_o}, 64'h0);
        end else begin
          e = exp_q.pop_front();
          chk("rd_resp", {28'h0, rd_valid_o, rd_data_o}, {28'h0, e});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    #2;
    chk("rst_rd_gnt", 64'(rd_gnt_o), 64'h0);
    chk("rst_wr_gnt", 64'(wr_gnt_o), 64'h0);
    chk("rst_re", 64'(ReadEnable), 64'h0);
    chk("rst_we", 64'(WriteEnable), 64'h0);
    chk("rst_rd_valid", 64'(rd_valid_o), 64'h0);
    chk("rst_rd_data", 64'(rd_data_o), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    next_cyc();

    // All four clients read; pointer starts at 0
    for (int c = 0; c < NC; c++) set_raddr(c, AW'(8 + c));
    rd_req_i = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_rd_gnt", 64'(rd_gnt_o), 64'(4'b0001 << (k % 4)));
      chk("rr_rd_addr", 64'(ReadAddr), 64'(8 + k % 4));
      push(4'(4'b0001 << (k % 4)), 32'hA000_0008 + 32'(k % 4));
      next_cyc();
    end
    rd_req_i = '0;

    // Client 2 writes 0xDEADBEEF to 7, then client 0 reads it back
    wr_req_i = 4'b0100;
    set_w(2, 5'd7, 32'hDEAD_BEEF);
    #1;
    chk("wr_gnt_c2", 64'(wr_gnt_o), 64'h4);
    chk("wr_en", 64'(WriteEnable), 64'h1);
    chk("wr_addr", 64'(WriteAddr), 64'd7);
    chk("wr_data", 64'(WriteData), 64'hDEAD_BEEF);
    chk("rd_idle_gnt", 64'(rd_gnt_o), 64'h0);
    next_cyc();
    wr_req_i = '0;
    rd_req_i = 4'b0001;
    set_raddr(0, 5'd7);
    #1;
    chk("rd_gnt_c0", 64'(rd_gnt_o), 64'h1);
    chk("rd_addr7", 64'(ReadAddr), 64'd7);
    chk("wr_idle_we", 64'(WriteEnable), 64'h0);
    chk("wr_idle_addr", 64'(WriteAddr), 64'h0);
    push(4'b0001, 32'hDEAD_BEEF);
    next_cyc();
    rd_req_i = '0;

    // Same-cycle read/write to addr 3: old word first, new word after
    wr_req_i = 4'b0010;
    set_w(1, 5'd3, 32'h9);
    #1 chk("wr_gnt_c1_a", 64'(wr_gnt_o), 64'h2);
    next_cyc();
    set_w(1, 5'd3, 32'h5);
    rd_req_i = 4'b1000;
    set_raddr(3, 5'd3);
    #1;
    chk("wr_gnt_c1_b", 64'(wr_gnt_o), 64'h2);
    chk("rd_gnt_c3_a", 64'(rd_gnt_o), 64'h8);
    push(4'b1000, 32'h9);
    next_cyc();
    wr_req_i = '0;
    #1 chk("rd_gnt_c3_b", 64'(rd_gnt_o), 64'h8);
    push(4'b1000, 32'h5);
    next_cyc();
    rd_req_i = '0;

    // Concurrent read by 0 and write by 1; then pointers observed at 1 and 2
    rd_req_i = 4'b0001;
    set_raddr(0, 5'd3);
    wr_req_i = 4'b0010;
    set_w(1, 5'd4, 32'h1234);
    #1;
    chk("both_rd_gnt", 64'(rd_gnt_o), 64'h1);
    chk("both_wr_gnt", 64'(wr_gnt_o), 64'h2);
    push(4'b0001, 32'h5);
    next_cyc();
    rd_req_i = 4'hF;
    wr_req_i = 4'hF;
    for (int c = 0; c < NC; c++) begin
      set_raddr(c, AW'(8 + c));
      set_w(c, AW'(20 + c), 32'h100 + 32'(c));
    end
    #1;
    chk("rd_ptr_1", 64'(rd_gnt_o), 64'h2);
    chk("wr_ptr_2", 64'(wr_gnt_o), 64'h4);
    chk("wr_addr_c2", 64'(WriteAddr), 64'd22);
    chk("wr_data_c2", 64'(WriteData), 64'h102);
    push(4'b0010, 32'hA000_0009);
    next_cyc();
    rd_req_i = '0;
    wr_req_i = '0;
    next_cyc();
    chk("idle_valid", 64'(rd_valid_o), 64'h0);
    chk("idle_hold_data", 64'(rd_data_o), 64'hA000_0009);

    // Read granted, reset asserted while its response is pending
    rd_req_i = 4'b0010;
    set_raddr(1, 5'd22);
    #1 chk("pre_rst_gnt", 64'(rd_gnt_o), 64'h2);
    next_cyc();
    rd_req_i = '0;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(rd_valid_o), 64'h0);
    chk("midrst_data", 64'(rd_data_o), 64'h0);
    chk("midrst_gnt", 64'(rd_gnt_o), 64'h0);
    repeat (2) next_cyc();
    rst_n = 1'b1;
    next_cyc();
    rd_req_i = 4'hF;
    wr_req_i = 4'hF;
    #1;
    chk("post_rst_rd_ptr", 64'(rd_gnt_o), 64'h1);
    chk("post_rst_wr_ptr", 64'(wr_gnt_o), 64'h1);
    push(4'b0001, 32'hA000_0008);
    next_cyc();
    wr_req_i = '0;

    // Lone requester granted every cycle
    rd_req_i = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #1 chk("single_gnt", 64'(rd_gnt_o), 64'h4);
      push(4'b0100, 32'hA000_000A);
      next_cyc();
    end
    rd_req_i = '0;
    repeat (3) next_cyc();
    chk("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
